multi_ch_event_sync: RTL and testbench
======================================

// Module: multi_ch_event_sync
// PURPOSE
//  N-channel event receiver in the destination clock domain.
//  - Synchronises asynchronous level/toggle lines from other domains.
//  - Detects per-channel edges according to a per-channel mode.
//  - Queues each event in a saturating per-channel pending counter, so events are never lost while the consumer stalls.
//  - Delivers queued events one at a time, round-robin, over a valid/ready interface.
//  - Sits between the MAC-side toggle generators and the control FSM.
// PARAMETERS
//  N_CH        4      number of channels (1..16); CH_W = max(1,$clog2(N_CH))
//  SYNC_STAGES 3      synchroniser depth incl. history flop (>=3)
//  CNT_W       4      pending-counter width; saturates at 2^CNT_W-1
//  EDGE_MODE   8'h00  2 bits per channel, ch i at [2i+1:2i]: 0 any edge (toggle protocol), 1 rising, 2 falling, 3 disabled
// PORTS
//  clk_des     in   1      destination clock; all logic on posedge
//  reset       in   1      synchronous, active-high reset
//  async_in    in   N_CH   asynchronous event lines, one per channel
//  evt_pulse   out  N_CH   registered 1-cycle detect pulse per channel (debug/monitor)
//  evt_valid   out  1      a queued event is presented
//  evt_ready   in   1      consumer accepts; handshake = evt_valid & evt_ready
//  evt_ch      out  CH_W   channel of presented event; stable while evt_valid & !evt_ready
//  pending_any out  1      OR of all pending counters != 0 (registered view)
//  ovf         out  N_CH   sticky: event arrived while that channel's counter was saturated
//  ovf_clear   in   1      clears all ovf bits
// BEHAVIOUR
//  Reset (sync, 1 cycle sufficient): every output and internal register goes to 0.
//   - Affected state: sync chains, counters, RR pointer (next search starts at ch0), arm counter.
//   - Outputs: evt_valid=0, evt_ch=0, evt_pulse=0, ovf=0, pending_any=0.
//   - Reset mid-operation discards all pending and presented events, with no partial handshake.
//  Arm: a counter runs SYNC_STAGES cycles after reset deasserts; evt_pulse is masked until it expires.
//   - An input held high through reset therefore produces no spurious event.
//  Sync: per channel, shift register s[SYNC_STAGES-1:0]; s[0]<=async_in.
//   - Edge detect compares s[S-1] (old) with s[S-2] (new).
//   - Mode 0 pulses on old!=new; mode 1 on !old&new; mode 2 on old&!new; mode 3 never pulses.
//  Latency: input sampled at edge E0 gives evt_pulse high for exactly one cycle after edge E0+S-1.
//   - pending increments at E0+S; evt_valid can rise at E0+S+1.
//  Pending counter per channel:
//   - +1 on evt_pulse.
//   - -1 on handshake for evt_ch.
//   - Both in the same cycle leaves the count unchanged.
//   - +1 at max leaves the count at max and sets ovf[ch].
//   - ovf_clear and a new overflow in the same cycle leaves the bit set.
//  Presentation register is loaded when !evt_valid or on a handshake:
//   - Candidates are channels with (count - this cycle's decrement) > 0.
//   - This cycle's increments are not considered.
//   - Round-robin search starts at last granted channel+1 (mod N_CH).
//   - No candidate gives evt_valid<=0.
//   - Back-to-back handshakes are allowed: evt_valid may stay high every cycle.
//   - The presented channel keeps count>=1 until its handshake; it is never withdrawn.
//   - evt_ready while !evt_valid is ignored.
//  Widths: counters unsigned CNT_W and never wrap; the RR pointer wraps N_CH-1 -> 0.
// TESTING
//  T1 ch0 mode1, async_in[0] 0->1 at E0, ready=1:
//     -> evt_pulse[0] after E2, evt_valid=1/evt_ch=0 after E4 for 1 cycle, then pending_any=0.
//  T2 ch1 mode0, two toggles 10 cycles apart:
//     -> exactly 2 handshakes on ch1; ch2 mode2 given a rising edge only -> no event.
//  T3 ch0..3 each get 1 event in the same cycle, ready=1:
//     -> evt_ch 0,1,2,3 on consecutive cycles with valid high throughout; repeat with last grant=2 -> order 3,0,1,2.
//  T4 ready=0, 17 events on ch1 (CNT_W=4):
//     -> counter 15, ovf[1]=1, evt_ch=1 stable.
//     -> then ready=1: exactly 15 handshakes.
//     -> ovf_clear -> ovf=0.
//  T5 pulse and handshake on the same channel, same cycle -> count unchanged; ovf_clear with a coincident overflow -> ovf stays 1.
//  T6 reset for 1 cycle while evt_valid=1 with 3 pending and async_in[0] held high:
//     -> outputs 0 next cycle.
//     -> no event after release.
//     -> a later falling edge on ch0 mode0 gives exactly 1 event.

Source files
------------

// File: rtl/multi_ch_event_sync_if.sv
// Event delivery handshake between multi_ch_event_sync and its consumer.
// The producer presents evt_ch with evt_valid; a transfer occurs when evt_valid & evt_ready.
interface multi_ch_event_sync_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;

    modport master (output evt_valid, output evt_ch, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/multi_ch_event_sync.sv
// N-channel asynchronous event receiver: synchronise, detect edges per mode, queue events
// in saturating per-channel counters and hand them out round-robin over valid/ready.
module multi_ch_event_sync #(
    parameter int                N_CH        = 4,
    parameter int                SYNC_STAGES = 3,
    parameter int                CNT_W       = 4,
    parameter logic [2*N_CH-1:0] EDGE_MODE   = '0
) (
    input  logic                  clk_des,
    input  logic                  reset,
    input  logic [N_CH-1:0]       async_in,
    output logic [N_CH-1:0]       evt_pulse,
    output logic                  pending_any,
    output logic [N_CH-1:0]       ovf,
    input  logic                  ovf_clear,
    multi_ch_event_sync_if.master evt
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SUM_W = CH_W + 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q [N_CH];
    logic [CNT_W-1:0]       cnt_q  [N_CH];
    logic [CNT_W-1:0]       cnt_d  [N_CH];
    logic [ARM_W-1:0]       arm_cnt;
    logic [N_CH-1:0]        edge_det;
    logic [N_CH-1:0]        dec;
    logic [N_CH-1:0]        cand;
    logic [N_CH-1:0]        ovf_set;
    logic [CH_W-1:0]        rr_start;
    logic [CH_W-1:0]        rr_next;
    logic [CH_W-1:0]        pick;
    logic                   found;
    logic                   armed;
    logic                   handshake;
    logic                   load;
    logic                   pend_next;

    assign armed     = (arm_cnt == ARM_W'(SYNC_STAGES));
    assign handshake = evt.evt_valid & evt.evt_ready;
    assign load      = !evt.evt_valid | handshake;
    assign rr_next   = (pick == CH_W'(N_CH - 1)) ? '0 : pick + CH_W'(1);

    // Oldest synchroniser stage is the history bit; the one before it is the fresh sample.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            case (EDGE_MODE[2*i +: 2])
                2'd0:    edge_det[i] = sync_q[i][SYNC_STAGES-1] ^ sync_q[i][SYNC_STAGES-2];
                2'd1:    edge_det[i] = !sync_q[i][SYNC_STAGES-1] & sync_q[i][SYNC_STAGES-2];
                2'd2:    edge_det[i] = sync_q[i][SYNC_STAGES-1] & !sync_q[i][SYNC_STAGES-2];
                default: edge_det[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any condition, so no latch is inferred.
        pend_next = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            dec[i]     = handshake && (evt.evt_ch == CH_W'(i));
            cand[i]    = cnt_q[i] > CNT_W'(dec[i]);
            ovf_set[i] = evt_pulse[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
            cnt_d[i]   = cnt_q[i];
            if (evt_pulse[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec[i] && !evt_pulse[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (cnt_d[i] != '0) begin
                pend_next = 1'b1;
            end
        end
    end

    // Round-robin: first candidate at or after rr_start, wrapping at N_CH.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [CH_W-1:0]  idx;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, rr_start} + SUM_W'(k);
            if (sum >= SUM_W'(N_CH)) begin
                sum = sum - SUM_W'(N_CH);
            end
            idx = sum[CH_W-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_des) begin
        if (reset) begin
            // NOTE: the counter and synchroniser arrays are plain flops, not RAM, so they are reset too.
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            arm_cnt       <= '0;
            evt_pulse     <= '0;
            pending_any   <= 1'b0;
            ovf           <= '0;
            rr_start      <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
            evt_pulse   <= armed ? edge_det : '0;
            pending_any <= pend_next;
            ovf         <= (ovf & ~{N_CH{ovf_clear}}) | ovf_set;
            if (load) begin
                evt.evt_valid <= found;
                if (found) begin
                    evt.evt_ch <= pick;
                    rr_start   <= rr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_ch_event_sync.sv
// Scoreboard bench for multi_ch_event_sync: a cycle-level reference model predicts outputs and
// the grant order; a negedge monitor compares the DUT against it. Directed scenarios plus random traffic.
module tb_multi_ch_event_sync;
    localparam int N     = 5;
    localparam int S     = 3;
    localparam int CNT_W = 4;
    localparam int MAXC  = 15;
    // ch0 rising, ch1 any, ch2 falling, ch3 any, ch4 disabled
    localparam logic [2*N-1:0] MODES = {2'd3, 2'd0, 2'd2, 2'd0, 2'd1};

    logic         clk_des = 1'b0;
    logic         reset;
    logic [N-1:0] async_in;
    logic [N-1:0] evt_pulse;
    logic         pending_any;
    logic [N-1:0] ovf;
    logic         ovf_clear;

    multi_ch_event_sync_if #(.N_CH(N)) evt ();

    multi_ch_event_sync #(
        .N_CH(N), .SYNC_STAGES(S), .CNT_W(CNT_W), .EDGE_MODE(MODES)
    ) dut (
        .clk_des(clk_des), .reset(reset), .async_in(async_in), .evt_pulse(evt_pulse),
        .pending_any(pending_any), .ovf(ovf), .ovf_clear(ovf_clear), .evt(evt)
    );

    always #5 clk_des = ~clk_des;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [2*N-1:0] modes = MODES;
    int             m_cnt [N];
    logic           m_valid = 1'b0;
    int             m_ch = 0;
    int             m_next = 0;
    int             since = 0;
    logic [N-1:0]   m_pulse = '0;
    logic [N-1:0]   m_ovf = '0;
    logic           m_pend = 1'b0;
    logic [N-1:0]   hist [S+1];
    int             exp_q [$];

    always @(posedge clk_des) begin : model
        logic         hs;
        logic [N-1:0] inc, dec, setv, oldv, newv;
        int           c;
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            foreach (hist[i]) hist[i] = '0;
            m_valid = 1'b0; m_ch = 0; m_next = 0; since = 0;
            m_pulse = '0; m_ovf = '0; m_pend = 1'b0;
            exp_q.delete();
        end else begin
            hs  = m_valid && evt.evt_ready;
            inc = m_pulse;
            dec = '0;
            if (hs) dec[m_ch] = 1'b1;
            if (!m_valid || hs) begin
                m_valid = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_next + k) % N;
                    if (!m_valid && (m_cnt[c] - int'(dec[c]) > 0)) begin
                        m_valid = 1'b1;
                        m_ch    = c;
                        m_next  = (c + 1) % N;
                        exp_q.push_back(c);
                    end
                end
            end
            setv = '0;
            for (int i = 0; i < N; i++) begin
                if (inc[i] && !dec[i]) begin
                    if (m_cnt[i] == MAXC) setv[i] = 1'b1;
                    else m_cnt[i]++;
                end else if (dec[i] && !inc[i]) begin
                    m_cnt[i]--;
                end
            end
            m_ovf = (ovf_clear ? '0 : m_ovf) | setv;
            for (int i = 0; i < S; i++) hist[i] = hist[i+1];
            hist[S] = async_in;
            oldv    = hist[0];
            newv    = hist[1];
            m_pulse = '0;
            if (since >= S) begin
                for (int i = 0; i < N; i++) begin
                    case (modes[2*i +: 2])
                        2'd0:    m_pulse[i] = oldv[i] != newv[i];
                        2'd1:    m_pulse[i] = !oldv[i] && newv[i];
                        2'd2:    m_pulse[i] = oldv[i] && !newv[i];
                        default: m_pulse[i] = 1'b0;
                    endcase
                end
            end else begin
                since++;
            end
            m_pend = 1'b0;
            foreach (m_cnt[i]) if (m_cnt[i] != 0) m_pend = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   hs_total = 0;
    int   hs_ch [N];
    int   log_ch [$];
    int   log_cyc [$];

    always @(posedge clk_des) cyc++;

    always @(negedge clk_des) begin : monitor
        int exp_ch;
        if (mon_en) begin
            check("evt_valid", evt.evt_valid, m_valid);
            check("evt_pulse", evt_pulse, m_pulse);
            check("pending_any", pending_any, m_pend);
            check("ovf", ovf, m_ovf);
            if (evt.evt_valid) begin
                exp_ch = (exp_q.size() > 0) ? exp_q[0] : -1;
                check("evt_ch", evt.evt_ch, exp_ch);
                if (evt.evt_ready && !reset) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_total++;
                    hs_ch[evt.evt_ch]++;
                    log_ch.push_back(int'(evt.evt_ch));
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_des);
            #1;
        end
    endtask

    task automatic toggle(input int ch, input int n, input int gap);
        repeat (n) begin
            async_in[ch] = ~async_in[ch];
            step(gap);
        end
    endtask

    // One event on every channel in m, all sampled on the same edge.
    task automatic fire(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i] && modes[2*i +: 2] == 2'd1) async_in[i] = 1'b0;
            if (m[i] && modes[2*i +: 2] == 2'd2) async_in[i] = 1'b1;
        end
        step(S + 2);
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                case (modes[2*i +: 2])
                    2'd1:    async_in[i] = 1'b1;
                    2'd2:    async_in[i] = 1'b0;
                    default: async_in[i] = ~async_in[i];
                endcase
            end
        end
        step(1);
    endtask

    task automatic wait_idle();
        int k = 0;
        step(S + 2);
        while ((evt.evt_valid || pending_any) && k < 300) begin
            step(1);
            k++;
        end
        check("idle_within_bound", k < 300, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, base1, base2, ch;
        int unsigned rdy_pct;
        int exp3 [4];
        exp3 = '{3, 0, 1, 2};
        foreach (hs_ch[i]) hs_ch[i] = 0;
        reset = 1'b1; async_in = '0; evt.evt_ready = 1'b0; ovf_clear = 1'b0;
        step(1);
        mon_en = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_valid", evt.evt_valid, 0);
        check("rst_ch", evt.evt_ch, 0);
        check("rst_pulse", evt_pulse, 0);
        check("rst_pending", pending_any, 0);
        check("rst_ovf", ovf, 0);
        step(S + 2);

        // T1: rising edge on ch0, latency check
        evt.evt_ready = 1'b1;
        async_in[0] = 1'b1;
        step(2);
        check("t1_no_pulse_e1", evt_pulse, 0);
        step(1);
        check("t1_pulse_e2", evt_pulse, 5'b00001);
        step(1);
        check("t1_pulse_gone_e3", evt_pulse, 0);
        check("t1_valid_low_e3", evt.evt_valid, 0);
        step(1);
        check("t1_valid_e4", evt.evt_valid, 1);
        check("t1_ch_e4", evt.evt_ch, 0);
        step(1);
        check("t1_valid_drop_e5", evt.evt_valid, 0);
        check("t1_pending_e5", pending_any, 0);

        // T2: two toggles on ch1; rising edge on falling-mode ch2
        wait_idle();
        base1 = hs_ch[1];
        toggle(1, 2, 10);
        base2 = hs_ch[2];
        async_in[2] = 1'b1;
        wait_idle();
        check("t2_ch1_events", hs_ch[1] - base1, 2);
        check("t2_ch2_events", hs_ch[2] - base2, 0);

        // T3: simultaneous events, round-robin order from a fresh reset and from last grant 2
        reset = 1'b1; step(1); reset = 1'b0;
        step(S + 2);
        log_ch.delete(); log_cyc.delete();
        fire(5'b01111);
        wait_idle();
        check("t3_count", log_ch.size(), 4);
        for (int i = 0; i < 4 && i < log_ch.size(); i++) begin
            check("t3_order", log_ch[i], i);
            check("t3_back_to_back", log_cyc[i] - log_cyc[0], i);
        end
        fire(5'b00100);
        wait_idle();
        log_ch.delete(); log_cyc.delete();
        fire(5'b01111);
        wait_idle();
        check("t3b_count", log_ch.size(), 4);
        for (int i = 0; i < 4 && i < log_ch.size(); i++) begin
            check("t3b_order", log_ch[i], exp3[i]);
            check("t3b_back_to_back", log_cyc[i] - log_cyc[0], i);
        end

        // T4: 17 events with consumer stalled -> saturation and overflow
        evt.evt_ready = 1'b0;
        base = hs_total;
        toggle(1, 17, 2);
        step(S + 2);
        check("t4_ovf1", ovf[1], 1);
        check("t4_valid", evt.evt_valid, 1);
        check("t4_ch", evt.evt_ch, 1);
        evt.evt_ready = 1'b1;
        wait_idle();
        check("t4_drain", hs_total - base, 15);
        ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
        check("t4_ovf_cleared", ovf, 0);

        // T5: pulse and handshake on the same channel in the same cycle
        evt.evt_ready = 1'b0;
        base = hs_total;
        toggle(3, 2, 2);
        step(S + 2);
        async_in[3] = ~async_in[3];
        step(3);
        evt.evt_ready = 1'b1;
        step(1);
        evt.evt_ready = 1'b0;
        step(2);
        check("t5_still_valid", evt.evt_valid, 1);
        evt.evt_ready = 1'b1;
        wait_idle();
        check("t5_total", hs_total - base, 3);
        // ovf_clear coincident with a new overflow
        evt.evt_ready = 1'b0;
        toggle(1, 15, 2);
        step(S + 2);
        check("t5_no_ovf_at_max", ovf[1], 0);
        async_in[1] = ~async_in[1];
        step(3);
        ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
        check("t5_ovf_wins_clear", ovf[1], 1);
        ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
        evt.evt_ready = 1'b1;
        wait_idle();

        // T6: reset while presenting with pending events and inputs held high
        evt.evt_ready = 1'b0;
        async_in[1] = 1'b1;
        toggle(3, 3, 2);
        step(S + 2);
        check("t6_pre_valid", evt.evt_valid, 1);
        reset = 1'b1; step(1); reset = 1'b0;
        check("t6_valid", evt.evt_valid, 0);
        check("t6_ch", evt.evt_ch, 0);
        check("t6_pulse", evt_pulse, 0);
        check("t6_ovf", ovf, 0);
        check("t6_pending", pending_any, 0);
        base = hs_total;
        base1 = hs_ch[1];
        evt.evt_ready = 1'b1;
        step(20);
        check("t6_no_spurious", hs_total - base, 0);
        async_in[1] = 1'b0;
        async_in[0] = 1'b0;
        wait_idle();
        check("t6_one_event", hs_total - base, 1);
        check("t6_on_ch1", hs_ch[1] - base1, 1);

        // Random traffic
        rdy_pct = 50;
        for (int t = 0; t < 3000; t++) begin
            if (t % 250 == 0) rdy_pct = $urandom_range(0, 100);
            evt.evt_ready = ($urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 5) == 0) begin
                ch = $urandom_range(0, N - 1);
                async_in[ch] = ~async_in[ch];
            end
            ovf_clear = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0; ovf_clear = 1'b0; evt.evt_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
